// File: rtl/branch_pkg.sv
// Shared types and helpers for the execute-side branch resolver.
// Record width is fixed by PKG_XLEN; the resolver's XLEN parameter must match it.
package branch_pkg;

    localparam int         PKG_XLEN = 32;
    localparam logic [1:0] CTR_WNT  = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        FLUSH
    } res_state_t;

    typedef struct packed {
        logic [PKG_XLEN-1:0] pc;
        logic                taken;
        logic [PKG_XLEN-1:0] target;
        logic [1:0]          ctr;
    } pred_rec_t;

    // 2-bit saturating counter step toward the actual outcome
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/branch_resolver_pred_queue.sv
// In-flight prediction FIFO: wrap-around pointers plus an occupancy count.
// Clear has priority over push/pop; pushes while full and pops while empty are ignored.
module pred_queue
    import branch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_clear,
    input  pred_rec_t              i_rec,
    output pred_rec_t              o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    pred_rec_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full & ~i_clear;
    assign w_do_pop  = i_pop & ~o_empty & ~i_clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_rec;
    end

endmodule

// File: rtl/branch_resolver.sv
// Resolves fetch predictions against execute outcomes: flush/redirect and BHT/BTB update.
// Define BRANCH_RESOLVER_PERF_EN to add br_count/mis_count performance counters.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int QDEPTH       = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = PKG_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pf_valid,
    input  logic [XLEN-1:0] pf_pc,
    input  logic            pf_taken,
    input  logic [XLEN-1:0] pf_target,
    input  logic [1:0]      pf_ctr,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic            upd_write,
    output logic [XLEN-1:0] upd_pc,
    output logic [1:0]      upd_ctr,
    output logic [XLEN-1:0] upd_target,
    output logic            q_full
`ifdef BRANCH_RESOLVER_PERF_EN
   ,output logic [31:0]     br_count,
    output logic [31:0]     mis_count
`endif
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    res_state_t               r_state, w_state_next;
    logic [FCW-1:0]           r_flush_cnt;
    logic [XLEN-1:0]          r_redirect_pc;
    logic                     r_upd_write;
    logic [XLEN-1:0]          r_upd_pc, r_upd_target;
    logic [1:0]               r_upd_ctr;
    pred_rec_t                w_rec, w_head;
    logic                     w_full, w_empty, w_active, w_push_acc, w_ex_acc, w_pop;
    logic                     w_hit, w_pred_taken, w_mispredict;
    logic [1:0]               w_pred_ctr;
    logic [$clog2(QDEPTH):0]  w_count;

    assign w_rec        = '{pc: pf_pc, taken: pf_taken, target: pf_target, ctr: pf_ctr};
    assign w_active     = (r_state != FLUSH);
    assign w_push_acc   = pf_valid & w_active & ~w_full;
    assign w_ex_acc     = ex_valid & w_active;
    assign w_pop        = w_ex_acc & ~w_empty;
    // A miss (empty queue or pc mismatch) is scored as a weakly-not-taken prediction
    assign w_hit        = ~w_empty & (w_head.pc == ex_pc);
    assign w_pred_taken = w_hit & w_head.taken;
    assign w_pred_ctr   = w_hit ? w_head.ctr : CTR_WNT;
    assign w_mispredict = w_ex_acc & ((w_pred_taken != ex_taken) |
                          (w_pred_taken & ex_taken & (w_head.target != ex_target)));

    pred_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_acc),
        .i_pop   (w_pop),
        .i_clear (w_mispredict),
        .i_rec   (w_rec),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_mispredict)    w_state_next = FLUSH;
                else if (w_push_acc) w_state_next = TRACK;
            end
            TRACK: begin
                if (w_mispredict) w_state_next = FLUSH;
                else if (w_pop && !w_push_acc && w_count == 1) w_state_next = IDLE;
            end
            FLUSH: begin
                if (r_flush_cnt == '0) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        flush       = (r_state == FLUSH);
        redirect_pc = flush ? r_redirect_pc : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flush_cnt   <= '0;
            r_redirect_pc <= '0;
            r_upd_write   <= 1'b0;
            r_upd_pc      <= '0;
            r_upd_ctr     <= '0;
            r_upd_target  <= '0;
        end else begin
            if (w_mispredict) begin
                r_flush_cnt   <= FCW'(FLUSH_CYCLES - 1);
                r_redirect_pc <= ex_taken ? ex_target : ex_pc + XLEN'(4);
            end else if (r_state == FLUSH && r_flush_cnt != '0) begin
                r_flush_cnt   <= r_flush_cnt - FCW'(1);
            end
            r_upd_write <= w_ex_acc;
            if (w_ex_acc) begin
                r_upd_pc     <= ex_pc;
                r_upd_ctr    <= sat_update(w_pred_ctr, ex_taken);
                r_upd_target <= ex_target;
            end
        end
    end

    assign upd_write  = r_upd_write;
    assign upd_pc     = r_upd_pc;
    assign upd_ctr    = r_upd_ctr;
    assign upd_target = r_upd_target;
    assign q_full     = w_full;

`ifdef BRANCH_RESOLVER_PERF_EN
    logic [31:0] r_br_count, r_mis_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_br_count  <= '0;
            r_mis_count <= '0;
        end else begin
            if (w_ex_acc)     r_br_count  <= r_br_count + 32'd1;
            if (w_mispredict) r_mis_count <= r_mis_count + 32'd1;
        end
    end

    assign br_count  = r_br_count;
    assign mis_count = r_mis_count;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: a behavioural model queues expected updates
// when stimulus is driven; they are popped and compared when the DUT strobes upd_write.
module tb_branch_resolver;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic [1:0]  ctr;
    } rec_t;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  ctr;
        logic [31:0] target;
    } exp_t;

    logic        clk, rst;
    logic        pf_valid, pf_taken, ex_valid, ex_taken;
    logic [31:0] pf_pc, pf_target, ex_pc, ex_target;
    logic [1:0]  pf_ctr;
    logic        flush, upd_write, q_full;
    logic [31:0] redirect_pc, upd_pc, upd_target;
    logic [1:0]  upd_ctr;
`ifdef BRANCH_RESOLVER_PERF_EN
    logic [31:0] br_count, mis_count;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    rec_t mq[$];
    exp_t sb_q[$];
    int   m_left  = 0;
    logic [31:0] m_redir = '0;

    branch_resolver #(.QDEPTH(4), .FLUSH_CYCLES(2), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .pf_valid(pf_valid), .pf_pc(pf_pc), .pf_taken(pf_taken),
        .pf_target(pf_target), .pf_ctr(pf_ctr),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .flush(flush), .redirect_pc(redirect_pc),
        .upd_write(upd_write), .upd_pc(upd_pc), .upd_ctr(upd_ctr),
        .upd_target(upd_target), .q_full(q_full)
`ifdef BRANCH_RESOLVER_PERF_EN
       ,.br_count(br_count), .mis_count(mis_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_sat(input logic [1:0] c, input logic t);
        int v;
        v = int'(c) + (t ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return v[1:0];
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_flush"}, flush, 0);
        chk({tag, "_redirect"}, redirect_pc, 0);
        chk({tag, "_upd_write"}, upd_write, 0);
        chk({tag, "_upd_pc"}, upd_pc, 0);
        chk({tag, "_upd_ctr"}, upd_ctr, 0);
        chk({tag, "_upd_target"}, upd_target, 0);
        chk({tag, "_q_full"}, q_full, 0);
    endtask

    // One clock of stimulus: drive, advance the model, clock, then score at negedge
    task automatic cycle(input logic pv, input logic [31:0] ppc, input logic pt,
                         input logic [31:0] ptg, input logic [1:0] pc2,
                         input logic ev, input logic [31:0] epc, input logic et,
                         input logic [31:0] etg);
        int          sz;
        logic        mis, hit, ptk;
        logic [1:0]  c;
        logic [31:0] ptgt;
        exp_t        e;
        pf_valid = pv; pf_pc = ppc; pf_taken = pt; pf_target = ptg; pf_ctr = pc2;
        ex_valid = ev; ex_pc = epc; ex_taken = et; ex_target = etg;
        sz  = mq.size();
        mis = 1'b0;
        if (m_left == 0) begin
            if (ev) begin
                hit  = (sz > 0) && (mq[0].pc == epc);
                ptk  = hit ? mq[0].taken  : 1'b0;
                c    = hit ? mq[0].ctr    : 2'b01;
                ptgt = hit ? mq[0].target : 32'h0;
                if (sz > 0) void'(mq.pop_front());
                mis = (ptk != et) || (ptk && et && (ptgt != etg));
                sb_q.push_back('{pc: epc, ctr: model_sat(c, et), target: etg});
                if (mis) m_redir = et ? etg : epc + 32'd4;
            end
            if (pv && sz < 4 && !mis) mq.push_back('{pc: ppc, taken: pt, target: ptg, ctr: pc2});
            if (mis) begin
                mq.delete();
                m_left = 2;
            end
        end else begin
            m_left--;
        end
        @(posedge clk);
        @(negedge clk);
        chk("flush", flush, m_left > 0);
        chk("redirect_pc", redirect_pc, (m_left > 0) ? m_redir : 32'h0);
        chk("q_full", q_full, mq.size() == 4);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("upd_write", upd_write, 1);
            chk("upd_pc", upd_pc, e.pc);
            chk("upd_ctr", upd_ctr, e.ctr);
            chk("upd_target", upd_target, e.target);
            $display("[TB] t=%0t update pc=0x%0h ctr=%0d tgt=0x%0h flush=%0b",
                     $time, upd_pc, upd_ctr, upd_target, flush);
        end else begin
            chk("upd_write_idle", upd_write, 0);
        end
    endtask

    task automatic push(input logic [31:0] p, input logic t, input logic [31:0] tg, input logic [1:0] c);
        cycle(1'b1, p, t, tg, c, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic [31:0] p, input logic t, input logic [31:0] tg);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b1, p, t, tg);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        // Reset held with random inputs
        for (int i = 0; i < 2; i++) begin
            pf_valid = 1'($urandom); pf_pc = $urandom; pf_taken = 1'($urandom);
            pf_target = $urandom; pf_ctr = 2'($urandom);
            ex_valid = 1'($urandom); ex_pc = $urandom; ex_taken = 1'($urandom);
            ex_target = $urandom;
            @(posedge clk);
            @(negedge clk);
            check_all_zero("reset");
        end
        rst = 1'b1;
        idle(1);

        // Cold miss: predicted not-taken, actually taken
        push(32'h04, 1'b0, 32'h0, 2'b01);
        resolve(32'h04, 1'b1, 32'h14);
        idle(3);

        // Correct prediction, then saturation
        push(32'h04, 1'b1, 32'h14, 2'b10);
        resolve(32'h04, 1'b1, 32'h14);
        push(32'h04, 1'b1, 32'h14, 2'b11);
        resolve(32'h04, 1'b1, 32'h14);
        idle(1);

        // Target mismatch
        push(32'h08, 1'b1, 32'h18, 2'b11);
        resolve(32'h08, 1'b1, 32'h14);
        idle(3);

        // Not-taken mispredict -> pc+4, and PC wrap
        push(32'h10, 1'b1, 32'h14, 2'b10);
        resolve(32'h10, 1'b0, 32'h14);
        idle(3);
        push(32'hFFFF_FFFE, 1'b1, 32'h40, 2'b10);
        resolve(32'hFFFF_FFFE, 1'b0, 32'h40);
        idle(3);

        // Full queue: 5th push dropped, so its resolve is a miss with no flush
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 1'b0, 32'h0, 2'b00);
        push(32'h110, 1'b1, 32'h200, 2'b11);
        cycle(1'b1, 32'h120, 1'b0, 32'h0, 2'b00, 1'b1, 32'h100, 1'b0, 32'h0);
        for (int i = 1; i < 4; i++) resolve(32'h100 + 32'(4 * i), 1'b0, 32'h0);
        resolve(32'h110, 1'b0, 32'h0);
        idle(1);

        // Events during flush are ignored
        resolve(32'h50, 1'b1, 32'h60);
        cycle(1'b1, 32'h50, 1'b1, 32'h60, 2'b11, 1'b1, 32'h50, 1'b1, 32'h90);
        cycle(1'b1, 32'h54, 1'b0, 32'h0, 2'b00, 1'b1, 32'h54, 1'b1, 32'h90);
        idle(1);

        // Simultaneous push+pop in TRACK
        push(32'h60, 1'b1, 32'h70, 2'b10);
        cycle(1'b1, 32'h64, 1'b0, 32'h0, 2'b00, 1'b1, 32'h60, 1'b1, 32'h70);
        resolve(32'h64, 1'b0, 32'h0);
        idle(1);

        // Random traffic over a small PC set
        for (int i = 0; i < 80; i++) begin
            cycle(1'($urandom), 32'h20 + 32'(4 * $urandom_range(0, 2)), 1'($urandom),
                  32'h40 + 32'(4 * $urandom_range(0, 1)), 2'($urandom),
                  1'($urandom), 32'h20 + 32'(4 * $urandom_range(0, 2)), 1'($urandom),
                  32'h40 + 32'(4 * $urandom_range(0, 1)));
        end
        idle(3);

        // Reset asserted mid-flush drops flush immediately
        push(32'h30, 1'b0, 32'h0, 2'b01);
        resolve(32'h30, 1'b1, 32'h80);
        #2 rst = 1'b0;
        #1;
        check_all_zero("rst_mid_flush");
        mq.delete();
        sb_q.delete();
        m_left = 0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_hold");
        rst = 1'b1;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
